// File: rtl/ldr_decode_port_if.sv
// Processor load-port bundle: request/address in, registered word/error out, ack to retire.
// master = processor side, slave = decoder side.
interface ldr_decode_port_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        rd_ack;

    modport master (
        output rd_req, rd_addr, rd_ack,
        input  rd_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  rd_req, rd_addr, rd_ack,
        output rd_ready, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/ldr_decode_port.sv
// Load decoder: routes byte addresses to data memory (0-1023) or sprite regs (1024-1035); LDR_STATUS_EN adds sticky buttons at 1036-1039.
// Latency: register/unmapped reads valid 1 cycle after accept, memory reads MEM_LATENCY+1 edges after accept.
// Backpressure: one outstanding load; rd_ready only in IDLE, response held until rd_ack.
module ldr_decode_port #(
    parameter int MEM_LATENCY = 1,
    parameter int MEM_AW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    ldr_decode_port_if.slave    rd,
    output logic                mem_rd_en,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [31:0]         mem_rdata,
    input  logic [31:0]         player_pos,
    input  logic [31:0]         enemy1_pos,
    input  logic [31:0]         enemy2_pos,
    input  logic [3:0]          btn
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [2:0]  cnt;
    logic [29:0] word;
    logic        hit_mem;
    logic        hit_player;
    logic        hit_enemy1;
    logic        hit_enemy2;
    logic [31:0] reg_data;
    logic        reg_err;
    logic        unused_addr;

    // Decode on the word index so the two ignored byte bits never matter.
    assign word        = rd.rd_addr[31:2];
    assign hit_mem     = (word < 30'd256);
    assign hit_player  = (word == 30'd256);
    assign hit_enemy1  = (word == 30'd257);
    assign hit_enemy2  = (word == 30'd258);
    assign unused_addr = ^rd.rd_addr[1:0];

`ifdef LDR_STATUS_EN
    logic       hit_status;
    logic [3:0] sticky;

    assign hit_status = (word == 30'd259);

    // Set wins over the read-clear so a press on the accept edge is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= ((accept && hit_status) ? 4'b0000 : sticky) | btn;
        end
    end
`else
    logic unused_btn;
    assign unused_btn = ^btn;
`endif

    always_comb begin
        reg_data = '0;
        reg_err  = 1'b1;
        if (hit_player) begin
            reg_data = player_pos;
            reg_err  = 1'b0;
        end else if (hit_enemy1) begin
            reg_data = enemy1_pos;
            reg_err  = 1'b0;
        end else if (hit_enemy2) begin
            reg_data = enemy2_pos;
            reg_err  = 1'b0;
        end
`ifdef LDR_STATUS_EN
        else if (hit_status) begin
            reg_data = {28'b0, sticky};
            reg_err  = 1'b0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (rd.rd_req) begin
                    accept    = 1'b1;
                    state_nxt = hit_mem ? MEM_WAIT : RESP;
                end
            end
            MEM_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rd.rd_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd.rd_data <= '0;
            rd.rd_err  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            cnt        <= '0;
        end else begin
            state     <= state_nxt;
            mem_rd_en <= accept && hit_mem;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit_mem) begin
                            mem_addr <= rd.rd_addr[MEM_AW+1:2];
                            cnt      <= MEM_LATENCY[2:0];
                        end else begin
                            rd.rd_data <= reg_data;
                            rd.rd_err  <= reg_err;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (cnt == 3'd0) begin
                        rd.rd_data <= mem_rdata;
                        rd.rd_err  <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd.rd_ready = (state == IDLE);
    assign rd.rd_valid = (state == RESP);

endmodule

// File: tb/tb_ldr_decode_port.sv
// Bench for ldr_decode_port: transaction-level model + per-cycle compare, directed literal vectors, MEM_LATENCY=3 reset case.
`timescale 1ns/1ps
module tb_ldr_decode_port;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
`ifdef LDR_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rst3;
    logic        mem_rd_en, mem_rd_en3;
    logic [7:0]  mem_addr, mem_addr3;
    logic [31:0] mem_rdata, mem_rdata3;
    logic [31:0] player_pos, enemy1_pos, enemy2_pos;
    logic [3:0]  btn;

    always #5 clk = ~clk;

    ldr_decode_port_if bus();
    ldr_decode_port_if bus3();

    ldr_decode_port #(.MEM_LATENCY(LAT), .MEM_AW(8)) u_dut (
        .clk(clk), .rst(rst), .rd(bus),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .player_pos(player_pos), .enemy1_pos(enemy1_pos), .enemy2_pos(enemy2_pos),
        .btn(btn)
    );

    ldr_decode_port #(.MEM_LATENCY(LAT3), .MEM_AW(8)) u_dut3 (
        .clk(clk), .rst(rst3), .rd(bus3),
        .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
        .player_pos(player_pos), .enemy1_pos(enemy1_pos), .enemy2_pos(enemy2_pos),
        .btn(btn)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    // Memory: data is valid only in the single cycle LAT edges after the strobe is sampled.
    logic [31:0] memarr [256];
    logic [7:0]  pend_addr  = '0;
    logic [7:0]  pend_addr3 = '0;
    int          pend_cnt   = 0;
    int          pend_cnt3  = 0;

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            pend_addr <= mem_addr;
            pend_cnt  <= LAT;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
        if (mem_rd_en3 === 1'b1) begin
            pend_addr3 <= mem_addr3;
            pend_cnt3  <= LAT3;
        end else if (pend_cnt3 > 0) begin
            pend_cnt3 <= pend_cnt3 - 1;
        end
    end

    assign mem_rdata  = (pend_cnt == 1)  ? memarr[pend_addr]  : 32'hBAD0_BAD0;
    assign mem_rdata3 = (pend_cnt3 == 1) ? memarr[pend_addr3] : 32'hBAD0_BAD0;

    // Transaction model of the main DUT.
    int          cyc      = 0;
    bit          m_live   = 1'b0;
    bit          m_idle   = 1'b1;
    bit          m_is_mem = 1'b0;
    bit          m_clr    = 1'b0;
    int          m_due    = 0;
    int          m_strobe = -1;
    logic [31:0] m_data   = '0;
    logic        m_err    = 1'b0;
    logic [7:0]  m_maddr  = '0;
    logic [3:0]  m_sticky = '0;

    function automatic void decode(input logic [31:0] a, output bit is_mem,
                                   output logic [31:0] d, output logic e);
        is_mem = 1'b0;
        d      = '0;
        e      = 1'b0;
        if (a < 32'd1024) begin
            is_mem = 1'b1;
            d      = memarr[a / 4];
        end else if (a < 32'd1028) d = player_pos;
        else if (a < 32'd1032)     d = enemy1_pos;
        else if (a < 32'd1036)     d = enemy2_pos;
        else if (STATUS && a < 32'd1040) d = {28'b0, m_sticky};
        else e = 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live   = 1'b1;
            m_idle   = 1'b1;
            m_is_mem = 1'b0;
            m_due    = 0;
            m_strobe = -1;
            m_data   = '0;
            m_err    = 1'b0;
            m_maddr  = '0;
            m_sticky = '0;
        end else if (m_live) begin
            m_clr = 1'b0;
            if (m_idle) begin
                if (bus.rd_req) begin
                    decode(bus.rd_addr, m_is_mem, m_data, m_err);
                    m_idle = 1'b0;
                    if (m_is_mem) begin
                        m_due    = cyc + 1 + LAT;
                        m_strobe = cyc;
                        m_maddr  = bus.rd_addr[9:2];
                    end else begin
                        m_due    = cyc;
                        m_strobe = -1;
                        m_clr    = STATUS && bus.rd_addr >= 32'd1036 && bus.rd_addr < 32'd1040;
                    end
                end
            end else if (cyc > m_due && bus.rd_ack) begin
                m_idle = 1'b1;
            end
            m_sticky = (m_clr ? 4'b0000 : m_sticky) | btn;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk1("m_ready", bus.rd_ready, m_idle);
            chk1("m_valid", bus.rd_valid, !m_idle && cyc >= m_due);
            chk1("m_rd_en", mem_rd_en, !m_idle && cyc == m_strobe);
            if (!m_idle && cyc >= m_due) begin
                chk32("m_data", bus.rd_data, m_data);
                chk1("m_err", bus.rd_err, m_err);
            end
            if (!m_idle && m_is_mem) chk32("m_mem_addr", {24'b0, mem_addr}, {24'b0, m_maddr});
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    // exp_edges counts edges after the accept edge before rd_valid is seen high.
    task automatic do_read(input string tag, input logic [31:0] addr, input int exp_edges,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_pulses, output logic [7:0] maddr);
        int k;
        int pulses;
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_req = 1'b0;
        maddr  = mem_addr;
        k      = 0;
        pulses = 0;
        while (bus.rd_valid !== 1'b1 && k < 20) begin
            if (mem_rd_en === 1'b1) pulses++;
            @(negedge clk);
            k++;
        end
        chk32({tag, "_lat"}, k, exp_edges);
        chk32({tag, "_pulses"}, pulses, exp_pulses);
        chk32({tag, "_data"}, bus.rd_data, exp_data);
        chk1({tag, "_err"}, bus.rd_err, exp_err);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk1({tag, "_ack_valid"}, bus.rd_valid, 1'b0);
        chk1({tag, "_ack_ready"}, bus.rd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] ma;
        int k;
        rst  = 1'b1;
        rst3 = 1'b1;
        bus.rd_req  = 1'b0; bus.rd_addr  = '0; bus.rd_ack  = 1'b0;
        bus3.rd_req = 1'b0; bus3.rd_addr = '0; bus3.rd_ack = 1'b0;
        player_pos = 32'h11; enemy1_pos = 32'h22; enemy2_pos = 32'h33;
        btn = 4'b0000;
        for (int i = 0; i < 256; i++) memarr[i] = 32'h5A00_0000 + i;
        memarr[255] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        chk1("rst_ready", bus.rd_ready, 1'b1);
        chk1("rst_valid", bus.rd_valid, 1'b0);
        chk1("rst_rd_en", mem_rd_en, 1'b0);
        chk32("rst_data", bus.rd_data, 32'h0);
        chk1("rst_err", bus.rd_err, 1'b0);
        chk32("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_read("mem_3fc", 32'h0000_03FC, 2, 32'hDEAD_BEEF, 1'b0, 1, ma);
        chk32("mem_3fc_addr", {24'b0, ma}, 32'hFF);
        do_read("mem_000", 32'h0000_0000, 2, 32'h5A00_0000, 1'b0, 1, ma);
        do_read("mem_011", 32'h0000_0013, 2, 32'h5A00_0004, 1'b0, 1, ma);
        chk32("mem_011_addr", {24'b0, ma}, 32'h04);
        do_read("mem_1023", 32'd1023, 2, 32'hDEAD_BEEF, 1'b0, 1, ma);
        do_read("player", 32'd1024, 0, 32'h11, 1'b0, 0, ma);
        do_read("enemy1", 32'd1029, 0, 32'h22, 1'b0, 0, ma);
        do_read("enemy2", 32'd1034, 0, 32'h33, 1'b0, 0, ma);
        do_read("player_hi", 32'd1027, 0, 32'h11, 1'b0, 0, ma);
        do_read("enemy2_hi", 32'd1035, 0, 32'h33, 1'b0, 0, ma);
        do_read("unm_fffc", 32'hFFFF_FFFC, 0, 32'h0, 1'b1, 0, ma);
        do_read("unm_ffff", 32'hFFFF_FFFF, 0, 32'h0, 1'b1, 0, ma);
        do_read("unm_alias", 32'h0001_0000, 0, 32'h0, 1'b1, 0, ma);
        do_read("unm_1040", 32'd1040, 0, 32'h0, 1'b1, 0, ma);

`ifdef LDR_STATUS_EN
        btn = 4'b0101;
        @(negedge clk);
        btn = 4'b0000;
        do_read("stat_first", 32'd1036, 0, 32'h5, 1'b0, 0, ma);
        do_read("stat_clear", 32'd1036, 0, 32'h0, 1'b0, 0, ma);
        btn = 4'b0010;
        do_read("stat_race", 32'd1036, 0, 32'h0, 1'b0, 0, ma);
        btn = 4'b0000;
        do_read("stat_kept", 32'd1039, 0, 32'h2, 1'b0, 0, ma);
`else
        do_read("unm_1036", 32'd1036, 0, 32'h0, 1'b1, 0, ma);
        do_read("unm_1039", 32'd1039, 0, 32'h0, 1'b1, 0, ma);
`endif

        // Response must hold while ack is low, whatever the request side and sprites do.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'd1028;
        @(negedge clk);
        chk1("hold_valid0", bus.rd_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.rd_req  = (i % 2 == 0);
            bus.rd_addr = 32'h0000_0000;
            player_pos  = 32'h100 + i;
            enemy1_pos  = 32'h200 + i;
            @(negedge clk);
            chk1("hold_valid", bus.rd_valid, 1'b1);
            chk32("hold_data", bus.rd_data, 32'h22);
            chk1("hold_ready", bus.rd_ready, 1'b0);
            chk1("hold_rd_en", mem_rd_en, 1'b0);
        end
        bus.rd_req = 1'b0;
        player_pos = 32'h11;
        enemy1_pos = 32'h22;
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk1("hold_ack_valid", bus.rd_valid, 1'b0);
        chk1("hold_ack_ready", bus.rd_ready, 1'b1);

        // MEM_LATENCY=3 instance: full read, then reset in the middle of a wait.
        rst3 = 1'b0;
        bus3.rd_req  = 1'b1;
        bus3.rd_addr = 32'h0000_0010;
        @(negedge clk);
        bus3.rd_req = 1'b0;
        k = 0;
        while (bus3.rd_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk32("l3_lat", k, 32'd4);
        chk32("l3_data", bus3.rd_data, 32'h5A00_0004);
        bus3.rd_ack = 1'b1;
        @(negedge clk);
        bus3.rd_ack = 1'b0;

        bus3.rd_req  = 1'b1;
        bus3.rd_addr = 32'h0000_0014;
        @(negedge clk);
        bus3.rd_req = 1'b0;
        chk1("l3_strobe", mem_rd_en3, 1'b1);
        chk32("l3_mem_addr", {24'b0, mem_addr3}, 32'h05);
        @(negedge clk);
        chk1("l3_wait_rd_en", mem_rd_en3, 1'b0);
        chk1("l3_wait_valid", bus3.rd_valid, 1'b0);
        chk1("l3_wait_ready", bus3.rd_ready, 1'b0);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        chk1("l3_rst_ready", bus3.rd_ready, 1'b1);
        chk1("l3_rst_valid", bus3.rd_valid, 1'b0);
        chk1("l3_rst_rd_en", mem_rd_en3, 1'b0);
        chk32("l3_rst_data", bus3.rd_data, 32'h0);
        chk32("l3_rst_mem_addr", {24'b0, mem_addr3}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("l3_discard_valid", bus3.rd_valid, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ldr_decode_port.md
# ldr_decode_port

Load-side counterpart of the store address decoder: accepts processor load requests, decodes the 32-bit byte address into the same map (data memory 0–1023, player 1024–1027, enemy1 1028–1031, enemy2 1032–1035) and returns the read word over a valid/ack handshake. It sits between the processor's load path and the data memory and sprite position registers. It sequences the synchronous memory read latency.

## Interface
- MEM_LATENCY, 1: memory cycles from sampled mem_rd_en to valid mem_rdata (1–7).
- MEM_AW, 8: memory word-address width (256 words = 1024 bytes).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_req  input  1  load request; accepted when rd_req & rd_ready at a rising edge.
- rd_addr  input  32  unsigned byte address, sampled at acceptance; bits [1:0] ignored.
- rd_ready  output  1  high only in IDLE.
- rd_valid  output  1  response valid; high in RESP.
- rd_data  output  32  response word; stable while rd_valid.
- rd_err  output  1  unmapped address flag; stable while rd_valid.
- rd_ack  input  1  processor consumed response.
- mem_rd_en  output  1  one-cycle memory read strobe.
- mem_addr  output  MEM_AW  word address, rd_addr[MEM_AW+1:2] held from acceptance to RESP.
- mem_rdata  input  32  memory read data.
- player_pos, enemy1_pos, enemy2_pos  input  32 each  current sprite register contents.
- btn  input  4  raw button levels (used only with status feature).

## Operation
- States: IDLE, MEM_WAIT, RESP. Reset → IDLE; rd_valid, rd_err, mem_rd_en = 0; rd_data, mem_addr, wait counter, sticky bits = 0.
- IDLE, accepted address < 1024: latch mem_addr, load counter = MEM_LATENCY, → MEM_WAIT.
- IDLE, accepted 1024–1035: rd_data ← matching sprite input at the accept edge, rd_err ← 0, → RESP.
- IDLE, accepted unmapped (≥1036, or ≥1040 with status feature): rd_data ← 0, rd_err ← 1, → RESP.
- MEM_WAIT: mem_rd_en = 1 in first cycle only; counter decrements each edge; at the edge where counter is 0, rd_data ← mem_rdata, rd_err ← 0, → RESP.
- RESP: rd_valid = 1; rd_data/rd_err held; rd_ack at an edge → IDLE. rd_ack outside RESP ignored. rd_req ignored outside IDLE (no queuing).
- Comparisons are unsigned 32-bit; 0xFFFF_FFFF is unmapped, never wraps into memory.
- rst asserted in any state, including mid MEM_WAIT, returns to IDLE with reset values next edge; the pending memory datum is discarded.

## Timing
- Register targets/unmapped: accept at edge N → rd_valid high after edge N (1-cycle latency).
- Memory: accept at edge N → mem_rd_en high cycle N..N+1 → data captured at edge N+1+MEM_LATENCY → rd_valid after that edge (default: 2 cycles).
- rd_ack at edge M → rd_valid low and rd_ready high after M; next accept earliest at M+1.
- Sprite inputs and btn sampled only at edges; no combinational path from inputs to rd_data.

## Configuration
- LDR_STATUS_EN defined: address 1036–1039 maps to status register {28'b0, sticky[3:0]}. sticky[i] sets on any edge with btn[i]=1. A read captures sticky and clears it at the accept edge; a bit whose btn is high on that same edge stays set (set wins). Reset clears sticky.
- Not defined: 1036–1039 unmapped (rd_data 0, rd_err 1); btn unused, no sticky flops.

## Test plan
- Reset mid MEM_WAIT (MEM_LATENCY=3) → next cycle IDLE, rd_ready=1, rd_valid=0, mem_rd_en=0, rd_data=0.
- Read addr 0x3FC, memory returns 0xDEADBEEF → mem_addr=0xFF, single mem_rd_en pulse, rd_valid 2 cycles after accept, rd_data=0xDEADBEEF, rd_err=0.
- Read 1024/1029/1034 with player=0x11, enemy1=0x22, enemy2=0x33 → rd_data 0x11/0x22/0x33, 1-cycle latency each.
- Read 1036 without LDR_STATUS_EN and read 0xFFFFFFFC → rd_data=0, rd_err=1.
- With LDR_STATUS_EN: pulse btn=4'b0101, read 1036 → rd_data=0x5; read again → 0x0; btn[1] high on accept edge → returned value excludes bit1, sticky keeps bit1.
- Hold rd_ack low 5 cycles in RESP while rd_req toggles and sprite inputs change → rd_valid, rd_data stable, no new accept, mem_rd_en stays 0.
